// File: rtl/mem_boot_loader.sv
// mem_boot_loader
//
// Loads a program into the shared memory from a valid/ready byte stream.
// While loading, it owns the memory write port and keeps the CPU halted and
// in reset. When the load finishes, it releases the CPU to run from address 0.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   i_start           load request; i_base / i_len are latched on acceptance
//   i_base, i_len     first write address and byte count (0..2^ADDR_W)
//   i_abort           cancel a load in progress (honoured only while loading)
//   i_valid, i_data   stream byte; o_ready accepts it
//   o_mem_*           memory write port (registered)
//   o_cpu_hlt/o_cpu_rst  CPU gating (registered, rst is active-high)
//   o_busy, o_done, o_err, o_count  status
module mem_boot_loader #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RST_HOLD = 2   // must be >= 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_len,
  input  logic              i_abort,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_cpu_hlt,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W:0]   o_count
);

  localparam int unsigned CntW  = ADDR_W + 1;
  localparam int unsigned HoldW = $clog2(RST_HOLD + 1);

  typedef enum logic [2:0] {
    StParked,
    StRun,
    StDrain,
    StLoad,
    StHold
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CntW-1:0]     len_q, len_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                hlt_q, hlt_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [CntW-1:0]     count_inc;

  assign count_inc = count_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    count_d = count_q;
    hold_d  = hold_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      StParked, StRun: begin
        if (i_start) begin
          state_d = StDrain;
          base_d  = i_base;
          len_d   = i_len;
          count_d = '0;
        end
      end
      // One cycle with the CPU halted but out of reset, so an in-flight CPU
      // write retires before the loader takes the port.
      StDrain: begin
        if (len_q == '0) begin
          state_d = StHold;
          hold_d  = HoldW'(RST_HOLD - 1);
        end else begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        // Abort wins over a same-cycle handshake; that byte is dropped.
        if (i_abort) begin
          state_d = StParked;
          err_d   = 1'b1;
        end else if (i_valid) begin
          we_d    = 1'b1;
          addr_d  = base_q + count_q[ADDR_W-1:0];
          data_d  = i_data;
          count_d = count_inc;
          // Full-width compare so len = 2^ADDR_W terminates at the wrap.
          if (count_inc == len_q) begin
            state_d = StHold;
            hold_d  = HoldW'(RST_HOLD - 1);
          end
        end
      end
      StHold: begin
        if (hold_q == '0) begin
          state_d = StRun;
          done_d  = 1'b1;
        end else begin
          hold_d = hold_q - HoldW'(1);
        end
      end
      default: state_d = StParked;
    endcase

    // CPU gating is registered from the next state so it tracks state_q.
    hlt_d     = (state_d != StRun);
    cpu_rst_d = (state_d == StParked) || (state_d == StLoad) || (state_d == StHold);
    busy_d    = (state_d == StDrain) || (state_d == StLoad) || (state_d == StHold);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StParked;
      base_q    <= '0;
      len_q     <= '0;
      count_q   <= '0;
      hold_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      hlt_q     <= 1'b1;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      count_q   <= count_d;
      hold_q    <= hold_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      hlt_q     <= hlt_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_ready    = (state_q == StLoad);
  assign o_mem_we   = we_q;
  assign o_mem_addr = addr_q;
  assign o_mem_data = data_q;
  assign o_cpu_hlt  = hlt_q;
  assign o_cpu_rst  = cpu_rst_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_count    = count_q;

endmodule

// File: doc/mem_boot_loader.md
Name: mem_boot_loader

Overview:
- Sequences program loading into the SoC's shared 8-bit memory from a byte stream with a valid/ready handshake.
- While loading, it owns the memory write port and holds the CPU halted and in reset. When the load completes, it releases the CPU to run from address 0.
- Sits beside the CPU on the memory write-port mux. Its o_cpu_hlt and o_cpu_rst gate the CPU, so no CPU write can collide with a loader write.

Parameters:
- ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, memory/stream data width.
- RST_HOLD, 2, cycles o_cpu_rst stays asserted after the last write; must be at least 1.

Ports:
- clk  in  1  universal clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle load request; base and length are latched on acceptance.
- i_base  in  ADDR_W  first memory address to write.
- i_len  in  ADDR_W+1  byte count, 0..2^ADDR_W.
- i_abort  in  1  cancel the load in progress.
- i_valid  in  1  stream byte valid.
- i_data  in  DATA_W  stream byte.
- o_ready  out  1  loader accepts a stream byte this cycle.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  ADDR_W  write address.
- o_mem_data  out  DATA_W  write data.
- o_cpu_hlt  out  1  halt to the CPU.
- o_cpu_rst  out  1  reset to the CPU (active-high, as the CPU expects).
- o_busy  out  1  a load sequence is in progress.
- o_done  out  1  one-cycle pulse: load complete and CPU released.
- o_err  out  1  one-cycle pulse: load aborted.
- o_count  out  ADDR_W+1  bytes accepted in the current or last load.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to PARKED.
  - o_cpu_hlt=1, o_cpu_rst=1.
  - o_mem_we=0, o_mem_addr=0, o_mem_data=0.
  - o_ready=0, o_busy=0, o_done=0, o_err=0, o_count=0.
  - Deassertion is synchronous to clk. The first edge after deassertion samples inputs normally.
- All outputs are registered except o_ready, which is decoded from the state.
- States:
  - PARKED: hlt=1, rst=1, busy=0. i_start goes to DRAIN.
  - RUN: hlt=0, rst=0, busy=0. i_start goes to DRAIN.
  - DRAIN: exactly 1 cycle. hlt=1, rst=0, busy=1, so any CPU write already issued completes. Then:
    - latched length 0 goes to HOLD;
    - otherwise goes to LOAD.
  - LOAD: hlt=1, rst=1, busy=1, o_ready=1.
    - Byte handshake (i_valid && o_ready): the next cycle drives o_mem_we=1, o_mem_addr=base+k (mod 2^ADDR_W), o_mem_data=byte, where k is the byte index.
    - o_count increments on each handshake.
    - When the handshake that brings the count to the latched length occurs, the next state is HOLD.
    - i_abort in LOAD (priority over a same-cycle handshake, and that byte is dropped) goes to PARKED, pulses o_err and drops busy. Bytes already accepted are still written.
  - HOLD: hlt=1, rst=1, busy=1, o_ready=0. Lasts RST_HOLD cycles, counted from entry. Then goes to RUN with o_done pulsed in the first RUN cycle.
- o_mem_we is high for exactly one cycle per accepted byte, never outside the cycle after a handshake. The final byte's write occurs in the first HOLD cycle.
- i_start is accepted only in PARKED or RUN; it is ignored while busy. A new start clears o_count.
- i_abort outside LOAD is ignored.
- Address wrap: base=0xFF with len=2 writes 0xFF then 0x00.
- len=256 with base=0 writes the whole memory; no deadlock at the count wrap.
- Stream stalls (i_valid=0) are unbounded; the loader waits in LOAD.
- Throughput: 1 byte per cycle sustained.
- Asynchronous reset mid-LOAD returns to PARKED immediately; a pending write is dropped.

Test Plan:
- Reset, then start base=0x10 len=3 with bytes A1,B2,C3 back-to-back:
  - writes 0x10/A1, 0x11/B2, 0x12/C3 on consecutive cycles;
  - o_cpu_rst held for 2 cycles after the last write;
  - o_done pulses once; state RUN with hlt=0, rst=0; o_count=3.
- From RUN, start base=0xFF len=2 with i_valid toggling 1,0,0,1:
  - DRAIN lasts 1 cycle with hlt=1, rst=0;
  - writes go to 0xFF then 0x00; no o_mem_we during the stall cycles.
- Start with len=0: DRAIN, then HOLD for 2 cycles, then o_done; zero writes.
- Abort after 2 of 5 bytes, with a handshake in the same cycle as the abort:
  - exactly 2 writes; o_err pulses once;
  - state PARKED with hlt=1, rst=1; o_count=2.
- Assert i_start repeatedly during LOAD: ignored; latched base and len unchanged.
- Assert rst low mid-LOAD: all outputs immediately at their reset values; a following start/load of len=256, base=0 writes addresses 0..255 exactly once.
